// File: rtl/dac_load_router.sv
// rtl/dac_load_router.sv - routes one PS DMA stream to the waveform-load port of one of NUM_CH DAC drivers
module dac_load_router #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0] m_axis_tvalid,
    input  logic [NUM_CH-1:0] m_axis_tready,
    output logic [NUM_CH-1:0] select_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, PAYLOAD, FLUSH, DRAIN} state_t;

    state_t            state, state_next;
    logic              run;
    logic [LEN_W-1:0]  count;
    logic [CH_W-1:0]   ch;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    logic [7:0]        hdr_ch;
    logic [LEN_W-1:0]  hdr_len;
    logic              hdr_bad;
    logic [NUM_CH-1:0] ch_onehot;
    logic              ch_ready;
    logic              out_fire;
    logic              in_fire;
    logic              ready;
    logic              load;
    logic              done_next;
    logic              err_next;

    assign hdr_ch    = s_axis_tdata[7:0];
    assign hdr_len   = s_axis_tdata[16+LEN_W-1:16];
    assign hdr_bad   = 32'(hdr_ch) >= NUM_CH;
    assign ch_onehot = NUM_CH'(1) << ch;
    assign ch_ready  = m_axis_tready[ch];
    assign out_fire  = out_valid && ch_ready;

    // run holds ready low for the first edge after reset release
    assign s_axis_tready = ready && run;
    assign in_fire       = s_axis_tvalid && s_axis_tready;

    assign m_axis_tdata  = out_data;
    assign m_axis_tvalid = out_valid ? ch_onehot : '0;
    assign select_out    = (state == PAYLOAD || state == FLUSH) ? ch_onehot : '0;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        load       = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (s_axis_tvalid && run) begin
                    if (hdr_len == '0) begin
                        done_next = 1'b1;
                    end else if (hdr_bad) begin
                        err_next   = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                ready = !out_valid || ch_ready;
                if (s_axis_tvalid && run && ready) begin
                    load = 1'b1;
                    if (count == LEN_W'(1)) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!out_valid || ch_ready) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            DRAIN: begin
                ready = 1'b1;
                if (s_axis_tvalid && run && count == LEN_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            count     <= '0;
            ch        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            run  <= 1'b1;
            done <= done_next;
            err  <= err_next;
            if (state == IDLE && in_fire) begin
                ch    <= hdr_ch[CH_W-1:0];
                count <= hdr_len;
            end else if ((state == PAYLOAD || state == DRAIN) && in_fire) begin
                count <= count - LEN_W'(1);
            end
            // simultaneous load and unload keeps valid high for 1 beat/cycle
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= s_axis_tdata;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_load_router.sv
// tb/tb_dac_load_router.sv - directed self-checking bench for dac_load_router
module tb_dac_load_router;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [15:0]  m_axis_tvalid;
    logic [15:0]  m_axis_tready;
    logic [15:0]  select_out;
    logic         busy;
    logic         done;
    logic         err;

    int n_assert = 0;
    int n_fail   = 0;

    dac_load_router #(.NUM_CH(16), .DATA_W(256), .LEN_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .select_out    (select_out),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [255:0] hdr(input int c, input int n);
        logic [255:0] h;
        h        = '0;
        h[7:0]   = 8'(c);
        h[31:16] = 16'(n);
        return h;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mvalid"}, m_axis_tvalid, 0);
        chk({tag, "_select"}, select_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int sent;
        int got;
        int dones;

        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 16'hFFFF;
        tick();
        tick();
        chk("rst_sready", s_axis_tready, 0);
        chk("rst_mdata", m_axis_tdata, 0);
        chk_idle_outputs("rst");

        // Reset release with a header already presented
        rst           = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = hdr(5, 4);
        #1;
        chk("rel_sready_pre", s_axis_tready, 0);
        tick();
        chk("rel_sready_edge1", s_axis_tready, 0 + 1);
        chk_idle_outputs("rel");
        tick();
        chk("single_select", select_out, 16'h0020);
        chk("single_busy", busy, 1);
        chk("single_mvalid0", m_axis_tvalid, 0);
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = 256'hA + 256'(i);
            #1;
            chk("single_sready", s_axis_tready, 1);
            tick();
            chk("single_mvalid", m_axis_tvalid, 16'h0020);
            chk("single_mdata", m_axis_tdata, 256'hA + 256'(i));
            chk("single_done_early", done, 0);
        end
        s_axis_tvalid = 1'b0;
        #1;
        chk("single_flush_sready", s_axis_tready, 0);
        chk("single_flush_select", select_out, 16'h0020);
        tick();
        chk("single_done", done, 1);
        chk("single_select_off", select_out, 0);
        chk("single_mvalid_off", m_axis_tvalid, 0);
        chk("single_busy_off", busy, 0);
        tick();
        chk("single_done_pulse", done, 0);

        // Backpressure: ch=3, N=8, ready[3] toggling 1-0-1-0
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = hdr(3, 8);
        tick();
        chk("bp_select", select_out, 16'h0008);
        sent  = 0;
        got   = 0;
        dones = 0;
        for (int c = 0; c < 60 && !(got == 8 && dones > 0); c++) begin
            m_axis_tready    = 16'hFFFF;
            m_axis_tready[3] = ~c[0];
            s_axis_tvalid    = (sent < 8);
            s_axis_tdata     = 256'h100 + 256'(sent);
            #1;
            chk("bp_other_mvalid", m_axis_tvalid & 16'hFFF7, 0);
            if (m_axis_tvalid[3] && !m_axis_tready[3])
                chk("bp_stall_sready", s_axis_tready, 0);
            if (m_axis_tvalid[3] && m_axis_tready[3]) begin
                chk("bp_data", m_axis_tdata, 256'h100 + 256'(got));
                got++;
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
            tick();
            if (done) dones++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 16'hFFFF;
        chk("bp_beats", 256'(got), 8);
        chk("bp_dones", 256'(dones), 1);
        chk("bp_select_off", select_out, 0);
        tick();

        // Bad channel: ch=20, N=3, drained
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = hdr(20, 3);
        tick();
        chk("bad_err", err, 1);
        chk("bad_busy", busy, 1);
        chk("bad_select", select_out, 0);
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = 256'h55 + 256'(i);
            #1;
            chk("bad_sready", s_axis_tready, 1);
            chk("bad_mvalid", m_axis_tvalid, 0);
            tick();
            if (i < 2) chk("bad_done_early", done, 0);
            chk("bad_err_pulse", err, 0);
        end
        s_axis_tvalid = 1'b0;
        chk("bad_done", done, 1);
        chk("bad_busy_off", busy, 0);
        chk("bad_mvalid_end", m_axis_tvalid, 0);
        tick();

        // Length zero, then an immediate N=1 header
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = hdr(2, 0);
        tick();
        chk("len0_done", done, 1);
        chk("len0_select", select_out, 0);
        chk("len0_busy", busy, 0);
        chk("len0_sready", s_axis_tready, 1);
        s_axis_tdata = hdr(5, 1);
        tick();
        chk("len1_busy", busy, 1);
        chk("len1_select", select_out, 16'h0020);
        s_axis_tdata = 256'h77;
        tick();
        s_axis_tvalid = 1'b0;
        chk("len1_mvalid", m_axis_tvalid, 16'h0020);
        chk("len1_mdata", m_axis_tdata, 256'h77);
        tick();
        chk("len1_done", done, 1);
        chk("len1_select_off", select_out, 0);

        // Reset mid-payload: ch=7, N=10, reset after 4 beats
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = hdr(7, 10);
        tick();
        for (int i = 0; i < 4; i++) begin
            s_axis_tdata = 256'h200 + 256'(i);
            tick();
        end
        chk("mid_mvalid", m_axis_tvalid, 16'h0080);
        rst = 1'b0;
        #1;
        chk("mid_rst_sready", s_axis_tready, 0);
        chk("mid_rst_mdata", m_axis_tdata, 0);
        chk_idle_outputs("mid_rst");
        s_axis_tvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rel_sready", s_axis_tready, 1);
        chk_idle_outputs("mid_rel");
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = hdr(1, 2);
        tick();
        chk("re_select", select_out, 16'h0002);
        chk("re_mvalid0", m_axis_tvalid, 0);
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata = 256'h301 + 256'(i);
            tick();
            chk("re_mvalid", m_axis_tvalid, 16'h0002);
            chk("re_mdata", m_axis_tdata, 256'h301 + 256'(i));
        end
        s_axis_tvalid = 1'b0;
        tick();
        chk("re_done", done, 1);
        chk("re_select_off", select_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
